// File: rtl/lcd_timing_pkg.sv
// Shared state encoding, default HDP timing constants and counter sizing helper
// for the LCD frame scheduler.
package lcd_timing_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    BLANK,
    PORCH
  } lcdState_t;

  localparam int unsigned DEF_PACKETS_PER_LINE = 40;
  localparam int unsigned DEF_BLANK_PER_LINE   = 4;
  localparam int unsigned DEF_LINES            = 1280;
  localparam int unsigned DEF_BACK_PORCH       = 24;
  localparam int unsigned DEF_UPDATE_CYCLES    = 28;

  // Width needed to hold 0..modulo-1; never narrower than one bit.
  function automatic int unsigned cntWidth(input int unsigned modulo);
    return (modulo > 1) ? $clog2(modulo) : 1;
  endfunction

endpackage

// File: rtl/lcd_frame_scheduler_if.sv
// FIFO-side and HDP-side signal bundle of the LCD frame scheduler.
// master: the scheduler; slave: the FIFO / panel / control side.
interface lcd_frame_scheduler_if;

  logic        i_enable;
  logic        i_fifoEmpty;
  logic [31:0] i_fifoData;
  logic        o_fifoRead;
  logic [31:0] o_lcdData;
  logic        o_valid;
  logic        o_update;
  logic        o_frameStart;
  logic        o_frameDone;
  logic [15:0] o_underflowCount;

  modport master (
    input  i_enable, i_fifoEmpty, i_fifoData,
    output o_fifoRead, o_lcdData, o_valid, o_update,
    output o_frameStart, o_frameDone, o_underflowCount
  );

  modport slave (
    output i_enable, i_fifoEmpty, i_fifoData,
    input  o_fifoRead, o_lcdData, o_valid, o_update,
    input  o_frameStart, o_frameDone, o_underflowCount
  );

endinterface

// File: rtl/lcd_timing_counter.sv
// Modulo-MODULO counter with enable; tc flags the last count value so the
// caller can act on the wrap in the same cycle.
module lcd_timing_counter
  import lcd_timing_pkg::*;
#(
  parameter  int unsigned MODULO = 4,
  localparam int unsigned W      = cntWidth(MODULO)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         tc
);

  localparam logic [W-1:0] LAST = W'(MODULO - 1);

  assign tc = (count == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/lcd_frame_scheduler.sv
// HDP frame scheduler: streams PACKETS_PER_LINE FIFO words per line, then blank
// cycles, LINES lines, then a back porch. Optional stall counter: LCD_UNDERFLOW_COUNT_EN.
module lcd_frame_scheduler
  import lcd_timing_pkg::*;
#(
  parameter int unsigned PACKETS_PER_LINE = DEF_PACKETS_PER_LINE,
  parameter int unsigned BLANK_PER_LINE   = DEF_BLANK_PER_LINE,
  parameter int unsigned LINES            = DEF_LINES,
  parameter int unsigned BACK_PORCH       = DEF_BACK_PORCH,
  parameter int unsigned UPDATE_CYCLES    = DEF_UPDATE_CYCLES
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  lcd_frame_scheduler_if.master bus
);

  localparam int unsigned PW = cntWidth(PACKETS_PER_LINE);
  localparam int unsigned BW = cntWidth(BLANK_PER_LINE);
  localparam int unsigned LW = cntWidth(LINES);
  localparam int unsigned RW = cntWidth(BACK_PORCH);
  localparam int unsigned FW = cntWidth(UPDATE_CYCLES + 1);
  localparam logic [FW-1:0] UPDATE_LIMIT = FW'(UPDATE_CYCLES);

  lcdState_t state, nextState;

  logic          advance, blanking, porching, lineEnd, frameEnd, firstAdvance;
  logic          pktTc, blankTc, lineTc, porchTc;
  logic [PW-1:0] pktCount;
  logic [LW-1:0] lineCount;
  logic [BW-1:0] unusedBlankCount;
  logic [RW-1:0] unusedPorchCount;
  logic [FW-1:0] frameCount;

  logic [31:0] lcdData;
  logic        valid, update, frameStart, frameDone;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (bus.i_enable) nextState = ACTIVE;
      ACTIVE:  if (advance && pktTc) nextState = BLANK;
      BLANK:   if (blankTc) nextState = lineTc ? PORCH : ACTIVE;
      PORCH:   if (porchTc) nextState = bus.i_enable ? ACTIVE : IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    advance      = (state == ACTIVE) && !bus.i_fifoEmpty;
    blanking     = (state == BLANK);
    porching     = (state == PORCH);
    lineEnd      = blanking && blankTc;
    frameEnd     = porching && porchTc;
    // Packet 0 of line 0 is only ever consumed once per frame.
    firstAdvance = advance && (pktCount == '0) && (lineCount == '0);
  end

  lcd_timing_counter #(.MODULO(PACKETS_PER_LINE)) packetCounter (
    .clk(i_clock), .rst(i_reset), .en(advance), .count(pktCount), .tc(pktTc)
  );

  lcd_timing_counter #(.MODULO(BLANK_PER_LINE)) blankCounter (
    .clk(i_clock), .rst(i_reset), .en(blanking), .count(unusedBlankCount), .tc(blankTc)
  );

  lcd_timing_counter #(.MODULO(LINES)) lineCounter (
    .clk(i_clock), .rst(i_reset), .en(lineEnd), .count(lineCount), .tc(lineTc)
  );

  lcd_timing_counter #(.MODULO(BACK_PORCH)) porchCounter (
    .clk(i_clock), .rst(i_reset), .en(porching), .count(unusedPorchCount), .tc(porchTc)
  );

  // Only needs to reach UPDATE_CYCLES, so it saturates there instead of
  // spanning the whole frame.
  always_ff @(posedge i_clock) begin
    if (i_reset || state == IDLE || porching) begin
      frameCount <= '0;
    end else if ((advance || blanking) && frameCount < UPDATE_LIMIT) begin
      frameCount <= frameCount + FW'(1);
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      lcdData    <= '0;
      valid      <= 1'b0;
      update     <= 1'b0;
      frameStart <= 1'b0;
      frameDone  <= 1'b0;
    end else begin
      lcdData    <= advance ? bus.i_fifoData : '0;
      valid      <= advance;
      update     <= (advance || blanking) && (frameCount < UPDATE_LIMIT);
      frameStart <= firstAdvance;
      frameDone  <= frameEnd;
    end
  end

  assign bus.o_fifoRead   = advance;
  assign bus.o_lcdData    = lcdData;
  assign bus.o_valid      = valid;
  assign bus.o_update     = update;
  assign bus.o_frameStart = frameStart;
  assign bus.o_frameDone  = frameDone;

`ifdef LCD_UNDERFLOW_COUNT_EN
  logic [15:0] underflowCount;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      underflowCount <= '0;
    end else if (state == ACTIVE && bus.i_fifoEmpty && underflowCount != '1) begin
      underflowCount <= underflowCount + 16'd1;
    end
  end

  assign bus.o_underflowCount = underflowCount;
`else
  assign bus.o_underflowCount = '0;
`endif

endmodule

// File: doc/lcd_frame_scheduler.md
LCD_FRAME_SCHEDULER -- requirements
Module: lcd_frame_scheduler

Interface
REQ-001 Parameter PACKETS_PER_LINE, default 40: valid 32-bit packets per line (1280 px / 32).
REQ-002 Parameter BLANK_PER_LINE, default 4: zero-data, valid-low cycles closing each line.
REQ-003 Parameter LINES, default 1280: lines per frame.
REQ-004 Parameter BACK_PORCH, default 24: idle cycles after the last line.
REQ-005 Parameter UPDATE_CYCLES, default 28: advancing cycles per frame for which o_update is high.
REQ-006 i_clock  in  1  single clock for all logic; reset is synchronous and active-high.
REQ-007 i_reset  in  1  synchronous active-high reset.
REQ-008 i_enable  in  1  run frames; sampled only at frame boundaries.
REQ-009 i_fifoEmpty  in  1  show-ahead FIFO empty flag.
REQ-010 i_fifoData  in  32  show-ahead FIFO head word, valid while i_fifoEmpty=0.
REQ-011 o_fifoRead  out  1  FIFO pop strobe, combinational.
REQ-012 o_lcdData  out  32  HDP data word, registered.
REQ-013 o_valid  out  1  HDP valid, registered, aligned with o_lcdData.
REQ-014 o_update  out  1  HDP update, registered.
REQ-015 o_frameStart  out  1  one-cycle pulse on the first advancing cycle of a frame.
REQ-016 o_frameDone  out  1  one-cycle pulse on the last back-porch cycle.
REQ-017 o_underflowCount  out  16  stall-cycle count (see Configuration).

Function
REQ-018 States: IDLE, ACTIVE, BLANK, PORCH.
REQ-019 IDLE -> ACTIVE when i_enable=1; otherwise remain in IDLE.
REQ-020 In ACTIVE, o_fifoRead = !i_fifoEmpty.
REQ-021 In ACTIVE with i_fifoEmpty=0 (advancing cycle), the next edge loads o_lcdData<=i_fifoData, sets o_valid<=1, and increments the packet count; latency is 1 cycle from pop to output.
REQ-022 In ACTIVE with i_fifoEmpty=1 (stall): o_valid<=0, o_lcdData<=0, no counter advances, no pop.
REQ-023 After PACKETS_PER_LINE packets, transition to BLANK; the packet count wraps to 0.
REQ-024 BLANK lasts exactly BLANK_PER_LINE cycles with o_valid=0, o_lcdData=0, and no pops; blank cycles never stall.
REQ-025 On BLANK exit, the line count increments; if it reaches LINES, go to PORCH and wrap the line count to 0, else return to ACTIVE.
REQ-026 PORCH lasts exactly BACK_PORCH cycles with o_valid=0, o_lcdData=0, no pops.
REQ-027 On the last PORCH cycle, pulse o_frameDone; next state is ACTIVE if i_enable=1, else IDLE.
REQ-028 Deasserting i_enable mid-frame has no effect until the frame completes.
REQ-029 Frame cycle count: +1 on each advancing ACTIVE cycle and each BLANK cycle; clears at frame start.
REQ-030 o_update<=1 while frame cycle count < UPDATE_CYCLES; otherwise 0, including in IDLE and PORCH.
REQ-031 o_frameStart pulses in the cycle after the first advancing ACTIVE cycle of a frame; stalls before that cycle delay it.
REQ-032 Counters are sized by $clog2 of their parameter and wrap explicitly; no implicit overflow.

Reset
REQ-033 With i_reset=1 at an edge: state<=IDLE, all counters<=0, o_lcdData=0, and o_valid, o_update, o_frameStart, o_frameDone, o_underflowCount all 0.
REQ-034 Reset mid-frame aborts the frame, does not pulse o_frameDone, and drives o_fifoRead=0 from the next cycle.

Configuration
REQ-035 Macro LCD_UNDERFLOW_COUNT_EN, when defined: o_underflowCount increments on each stall cycle (REQ-022), saturates at 16'hFFFF, and clears only on reset.
REQ-036 Macro LCD_UNDERFLOW_COUNT_EN, when undefined: o_underflowCount is constant 0 and no counter logic is present.

Structure
REQ-037 Package lcd_timing_pkg holds the state enum and the default timing constants (40, 4, 1280, 24, 28).
REQ-038 Sub-module lcd_timing_counter (parameterised modulo counter with enable and terminal-count output) is instantiated for packet, blank, line and porch counts.

Verification (small parameters: PACKETS_PER_LINE=4, BLANK_PER_LINE=2, LINES=2, BACK_PORCH=3, UPDATE_CYCLES=5)
REQ-039 FIFO always non-empty, data 1,2,3...; i_enable=1 -> valid pattern 1111 00 1111 00 000 repeating; data 1-4, 5-8; o_frameDone every 15 cycles.
REQ-040 Empty FIFO for 3 cycles at packet 2 -> o_valid low for exactly 3 cycles; packets continue with no data loss or duplication; o_underflowCount=3 when the macro is defined, 0 when undefined.
REQ-041 o_update check -> high for the first 5 advancing cycles of each frame (4 packets + 1 blank), low in PORCH.
REQ-042 i_enable dropped at line 0 packet 1 -> frame completes, o_frameDone pulses once, then IDLE with o_fifoRead=0.
REQ-043 i_reset asserted mid-BLANK -> next cycle all outputs 0 and state IDLE; re-enable -> next frame starts at packet 0, line 0.
